// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared width, divide opcodes and divider FSM states
package div_unit_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] DIV  = 2'd0;
  localparam logic [1:0] DIVU = 2'd1;
  localparam logic [1:0] REM  = 2'd2;
  localparam logic [1:0] REMU = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
module div_unit
  import div_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  kill_i,
  input  logic [1:0]            divOp_i,
  input  logic [DATA_WIDTH-1:0] srcA_i,
  input  logic [DATA_WIDTH-1:0] srcB_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  div_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_divisor;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_quo;
  logic [4:0]            r_cnt;
  logic                  r_qsign;
  logic                  r_rsign;
  logic                  r_is_rem;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_result;

  logic                  w_signed;
  logic                  w_is_rem;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [DATA_WIDTH-1:0] w_a_mag;
  logic [DATA_WIDTH-1:0] w_b_mag;
  logic                  w_div_zero;
  logic                  w_overflow;
  logic [DATA_WIDTH-1:0] w_special_res;
  logic [DATA_WIDTH:0]   w_shift;
  logic [DATA_WIDTH:0]   w_trial;
  logic [DATA_WIDTH-1:0] w_rem_next;
  logic [DATA_WIDTH-1:0] w_quo_next;
  logic [DATA_WIDTH-1:0] w_q_res;
  logic [DATA_WIDTH-1:0] w_r_res;
  logic [DATA_WIDTH-1:0] w_final_res;

  assign w_signed   = (divOp_i == DIV) || (divOp_i == REM);
  assign w_is_rem   = (divOp_i == REM) || (divOp_i == REMU);
  assign w_a_neg    = w_signed & srcA_i[DATA_WIDTH-1];
  assign w_b_neg    = w_signed & srcB_i[DATA_WIDTH-1];
  assign w_a_mag    = w_a_neg ? (~srcA_i + 1'b1) : srcA_i;
  assign w_b_mag    = w_b_neg ? (~srcB_i + 1'b1) : srcB_i;
  assign w_div_zero = (srcB_i == '0);
  assign w_overflow = w_signed && (srcA_i == 32'h8000_0000) && (srcB_i == 32'hFFFF_FFFF);

  // Zero-divisor and signed-overflow results bypass the iteration entirely.
  always_comb begin
    w_special_res = '0;
    if (w_div_zero)
      w_special_res = w_is_rem ? srcA_i : '1;
    else if (!w_is_rem)
      w_special_res = 32'h8000_0000;
  end

  // One restoring step; the partial remainder is always below the divisor, so 32 bits hold it.
  assign w_shift     = {r_rem, r_quo[DATA_WIDTH-1]};
  assign w_trial     = w_shift - {1'b0, r_divisor};
  assign w_rem_next  = w_trial[DATA_WIDTH] ? w_shift[DATA_WIDTH-1:0] : w_trial[DATA_WIDTH-1:0];
  assign w_quo_next  = {r_quo[DATA_WIDTH-2:0], ~w_trial[DATA_WIDTH]};
  assign w_q_res     = r_qsign ? (~w_quo_next + 1'b1) : w_quo_next;
  assign w_r_res     = r_rsign ? (~w_rem_next + 1'b1) : w_rem_next;
  assign w_final_res = r_is_rem ? w_r_res : w_q_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_divisor <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_qsign   <= 1'b0;
      r_rsign   <= 1'b0;
      r_is_rem  <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      r_done <= 1'b0;
      if (kill_i) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (start_i) begin
              r_is_rem  <= w_is_rem;
              r_divisor <= w_b_mag;
              r_quo     <= w_a_mag;
              r_rem     <= '0;
              r_cnt     <= '0;
              r_qsign   <= w_a_neg ^ w_b_neg;
              r_rsign   <= w_a_neg;
              if (w_div_zero || w_overflow) begin
                r_result <= w_special_res;
                r_done   <= 1'b1;
                r_state  <= DONE;
              end else begin
                r_state <= CALC;
              end
            end
          end
          CALC: begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_result <= w_final_res;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy_o   = (r_state != IDLE);
  assign done_o   = r_done;
  assign result_o = r_result;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed-vector self-checking bench for div_unit
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        kill_i;
  logic [1:0]  divOp_i;
  logic [31:0] srcA_i;
  logic [31:0] srcB_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int errors = 0;
  int checks = 0;

  div_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .kill_i   (kill_i),
    .divOp_i  (divOp_i),
    .srcA_i   (srcA_i),
    .srcB_i   (srcB_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; start is sampled at the next rising edge (cycle 0).
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_cyc);
    int          done_cyc = 0;
    int          done_cnt = 0;
    int          busy_cnt = 0;
    logic [31:0] res = '0;
    start_i = 1'b1;
    divOp_i = op;
    srcA_i  = a;
    srcB_i  = b;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    srcA_i  = '0;
    srcB_i  = '0;
    for (int c = 1; c <= exp_cyc + 1; c++) begin
      if (c > 1) @(negedge clk);
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = c;
          res      = result_o;
        end
      end
    end
    check({tag, "_result"}, res, exp_res);
    check({tag, "_done_cycle"}, done_cyc, exp_cyc);
    check({tag, "_busy_cycles"}, busy_cnt, exp_cyc);
    check({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int done_cnt;
    logic busy10;
    logic busy11;

    rst     = 1'b1;
    start_i = 1'b0;
    kill_i  = 1'b0;
    divOp_i = DIV;
    srcA_i  = '0;
    srcB_i  = '0;
    #12;
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_result", result_o, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op("div_m7_2",     DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    do_op("rem_m7_2",     REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    do_op("divu_max_1",   DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33);
    do_op("remu_100_7",   REMU, 32'd100,       32'd7,         32'd2,         33);
    do_op("div_100_m7",   DIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
    do_op("div_ovf",      DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem_ovf",      REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    do_op("div_5_0",      DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    do_op("remu_5_0",     REMU, 32'd5,         32'd0,         32'd5,         1);

    // Kill at cycle 10, with a stray zero-divisor start at cycle 5 that must be ignored.
    busy_cnt = 0;
    done_cnt = 0;
    busy10   = 1'b0;
    busy11   = 1'b1;
    start_i  = 1'b1;
    divOp_i  = DIV;
    srcA_i   = 32'd100;
    srcB_i   = 32'hFFFF_FFF9;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) @(negedge clk);
      if (busy_o && c <= 10) busy_cnt++;
      if (done_o) done_cnt++;
      if (c == 10) busy10 = busy_o;
      if (c == 11) busy11 = busy_o;
      if (c == 5) begin
        start_i = 1'b1;
        divOp_i = DIVU;
        srcB_i  = 32'd0;
      end
      if (c == 6) start_i = 1'b0;
      if (c == 10) kill_i = 1'b1;
      if (c == 11) kill_i = 1'b0;
    end
    check("kill_busy_before", busy10, 1);
    check("kill_busy_after", busy11, 0);
    check("kill_busy_cycles", busy_cnt, 10);
    check("kill_no_done", done_cnt, 0);
    check("kill_result_held", result_o, 32'd5);

    do_op("after_kill",   DIVU, 32'd100,       32'd7,         32'd14,        33);

    // Asynchronous reset between edges in CALC cycle 20.
    start_i = 1'b1;
    divOp_i = DIVU;
    srcA_i  = 32'hFFFF_FFFF;
    srcB_i  = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 2; c <= 20; c++) @(negedge clk);
    check("arst_busy_before", busy_o, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_done", done_o, 0);
    check("arst_result", result_o, 0);
    #1 rst = 1'b0;
    @(negedge clk);

    do_op("after_rst",    DIVU, 32'hFFFF_FFFF, 32'd3,         32'h5555_5555, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
